// File: rtl/slow_memory_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slow_memory_model_pkg
// Description : Shared definitions for the multi-cycle line memory and the
//               cache controllers that talk to it: transfer FSM state
//               encoding and the cache line width.
// Revision    : 1.0 - initial release
// ============================================================================
package slow_memory_model_pkg;

    // Cache line width in bits; one transfer moves exactly one line.
    localparam int LINE_W = 128;

    // Transfer FSM states, shared with the cache controllers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage : slow_memory_model_pkg
`default_nettype wire

// File: rtl/slow_memory_model.sv
`default_nettype none
// ============================================================================
// Module      : slow_memory_model
// Description : Behavioural multi-cycle line memory. A request is accepted in
//               IDLE, the line address / data / operation are latched, and
//               after LATENCY cycles a one-cycle proc_ready pulse signals
//               completion. Writes commit and reads capture data at the edge
//               entering DONE. Contents live in the array 'mem' (preloadable
//               hierarchically, never cleared by reset).
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               proc_read  - read request, held until proc_ready
//               proc_write - write request, held until proc_ready (wins
//                            over proc_read when both are high)
//               proc_addr  - line address (byte address bits 31:4)
//               proc_wdata - write line data
//               proc_rdata - last completed read line (held)
//               proc_ready - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module slow_memory_model #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 8,
    parameter int LINE_W    = slow_memory_model_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [27:0]       proc_addr,
    input  logic [LINE_W-1:0] proc_wdata,
    output logic [LINE_W-1:0] proc_rdata,
    output logic              proc_ready
);
    import slow_memory_model_pkg::*;

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Line storage; intentionally outside the reset domain.
    logic [LINE_W-1:0] mem [0:DEPTH-1];

    mem_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]     wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic [LINE_W-1:0]     rdata_q, rdata_d;
    logic                  commit;

    // Upper line-address bits alias onto the same lines.
    logic addr_unused;
    assign addr_unused = ^proc_addr[27:ADDR_BITS];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (proc_read || proc_write) begin
                    addr_d  = proc_addr[ADDR_BITS-1:0];
                    wdata_d = proc_wdata;
                    is_wr_d = proc_write;
                    cnt_d   = CNT_W'(1);
                    // A single-cycle memory skips BUSY entirely.
                    state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The edge entering DONE is where the transfer takes effect. The
        // _d values are used so the LATENCY==1 path (IDLE->DONE) sees the
        // request being latched on that same edge.
        commit = (state_d == ST_DONE) && (state_q != ST_DONE);
        if (commit && !is_wr_d) begin
            rdata_d = mem[addr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset aborts any transfer, so a write is never committed while rst
    // is asserted.
    always_ff @(posedge clk) begin
        if (commit && is_wr_d && !rst) begin
            mem[addr_d] <= wdata_d;
        end
    end

    assign proc_rdata = rdata_q;
    assign proc_ready = (state_q == ST_DONE);

endmodule : slow_memory_model
`default_nettype wire

// File: tb/tb_slow_memory_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_memory_model
// Description : Self-checking bench for slow_memory_model. Two instances are
//               exercised: unit 0 with LATENCY=8 and unit 1 with LATENCY=1.
//               A reference model holds each memory as a plain array and
//               predicts read data and the ready latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_memory_model;

    localparam int ADDR_BITS = 10;
    localparam int DEPTH     = 2 ** ADDR_BITS;
    localparam int LINE_W    = 128;
    localparam int LAT0      = 8;
    localparam int LAT1      = 1;

    logic              clk;
    logic              rst;
    logic              rd    [2];
    logic              wr    [2];
    logic [27:0]       addr  [2];
    logic [LINE_W-1:0] wdata [2];
    logic [LINE_W-1:0] rdata [2];
    logic              ready [2];

    // Reference model state.
    logic [LINE_W-1:0] ref_mem [2][DEPTH];
    logic [LINE_W-1:0] ref_rd  [2];

    int n_cmp;
    int n_mis;

    slow_memory_model #(.ADDR_BITS(ADDR_BITS), .LATENCY(LAT0), .LINE_W(LINE_W)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (rd[0]),
        .proc_write (wr[0]),
        .proc_addr  (addr[0]),
        .proc_wdata (wdata[0]),
        .proc_rdata (rdata[0]),
        .proc_ready (ready[0])
    );

    slow_memory_model #(.ADDR_BITS(ADDR_BITS), .LATENCY(LAT1), .LINE_W(LINE_W)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (rd[1]),
        .proc_write (wr[1]),
        .proc_addr  (addr[1]),
        .proc_wdata (wdata[1]),
        .proc_rdata (rdata[1]),
        .proc_ready (ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called right after the acceptance edge (cycle 1). Waits for ready and
    // checks the latency in cycles plus the read data at that point.
    task automatic wait_ready(input int u, input string tag);
        int n = 1;
        while (ready[u] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, LINE_W'(n), LINE_W'(lat_of(u)));
        check({tag, "_rdata"}, rdata[u], ref_rd[u]);
    endtask

    // One complete transaction starting in IDLE (called #1 after an edge).
    // Inputs are scrambled after acceptance to show they are latched.
    task automatic run_txn(input int u, input bit r, input bit w,
                           input logic [27:0] a, input logic [LINE_W-1:0] d,
                           input string tag);
        int idx = int'(a[ADDR_BITS-1:0]);
        rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
        @(posedge clk); #1;
        rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 28'($urandom); wdata[u] = rand_line();
        if (w) ref_mem[u][idx] = d;
        else   ref_rd[u] = ref_mem[u][idx];
        wait_ready(u, tag);
        @(posedge clk); #1;
        check({tag, "_pulse1"}, LINE_W'(ready[u]), LINE_W'(0));
    endtask

    task automatic count_pulses(input int cycles, output int c0, output int c1);
        c0 = 0; c1 = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ready[0] === 1'b1) c0++;
            if (ready[1] === 1'b1) c1++;
        end
    endtask

    initial begin
        logic [LINE_W-1:0] x;
        logic [27:0]       a;
        int                c0, c1;

        n_cmp = 0; n_mis = 0;
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0; wdata[u] = '0;
        end

        // Preload both memories (and the model) with random contents.
        for (int i = 0; i < DEPTH; i++) begin
            x = rand_line();
            dut0.mem[i] = x; ref_mem[0][i] = x;
            x = rand_line();
            dut1.mem[i] = x; ref_mem[1][i] = x;
        end
        dut0.mem[5] = 128'h0123456789ABCDEF0123456789ABCDEF;
        ref_mem[0][5] = 128'h0123456789ABCDEF0123456789ABCDEF;

        // Asynchronous reset asserted mid-cycle.
        #3 rst = 1'b1;
        #1;
        check("rst_ready", LINE_W'(ready[0]), LINE_W'(0));
        check("rst_rdata", rdata[0], '0);
        check("rst_ready_l1", LINE_W'(ready[1]), LINE_W'(0));
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        count_pulses(20, c0, c1);
        check("idle_pulses", LINE_W'(c0), LINE_W'(0));
        check("idle_pulses_l1", LINE_W'(c1), LINE_W'(0));

        // Preloaded read, then data held.
        run_txn(0, 1, 0, 28'd5, '0, "preload_rd");
        repeat (10) @(posedge clk);
        #1;
        check("preload_hold", rdata[0], 128'h0123456789ABCDEF0123456789ABCDEF);

        // Write, read back, read through alias.
        run_txn(0, 0, 1, 28'h3A0, {4{32'hA5A5A5A5}}, "wr_3a0");
        run_txn(0, 1, 0, 28'h3A0, '0, "rd_3a0");
        check("rd_3a0_value", rdata[0], {4{32'hA5A5A5A5}});
        run_txn(0, 1, 0, 28'h7A0, '0, "rd_alias");

        // Simultaneous read+write is a write; rdata must not move.
        x = rand_line();
        run_txn(0, 1, 1, 28'd2, x, "rw_both");
        run_txn(0, 1, 0, 28'd2, '0, "rd_2");
        check("rd_2_value", rdata[0], x);

        // Reset aborts a write in flight.
        wr[0] = 1'b1; addr[0] = 28'd7; wdata[0] = rand_line();
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1; wr[0] = 1'b0;
        #1;
        check("abort_ready", LINE_W'(ready[0]), LINE_W'(0));
        check("abort_rdata", rdata[0], '0);
        ref_rd[0] = '0; ref_rd[1] = '0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        count_pulses(LAT0 + 4, c0, c1);
        check("abort_pulses", LINE_W'(c0), LINE_W'(0));
        run_txn(0, 1, 0, 28'd7, '0, "abort_rd7");

        // Back-to-back: read held one extra cycle after ready on each unit.
        for (int u = 0; u < 2; u++) begin
            a = 28'($urandom_range(0, 31));
            rd[u] = 1'b1; addr[u] = a;
            @(posedge clk); #1;
            ref_rd[u] = ref_mem[u][int'(a[ADDR_BITS-1:0])];
            wait_ready(u, "b2b_first");
            @(posedge clk); #1;
            check("b2b_gap", LINE_W'(ready[u]), LINE_W'(0));
            @(posedge clk); #1;
            rd[u] = 1'b0;
            wait_ready(u, "b2b_second");
            @(posedge clk); #1;
        end

        // Randomized traffic on both units (small index window to get hits).
        for (int k = 0; k < 40; k++) begin
            int u = (k % 3 == 2) ? 1 : 0;
            bit r = 1'($urandom);
            bit w = ($urandom_range(0, 2) == 0);
            if (!r && !w) r = 1'b1;
            a = {18'($urandom), 10'($urandom_range(0, 15))};
            run_txn(u, r, w, a, rand_line(), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got no-finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_slow_memory_model
`default_nettype wire
